// File: rtl/divider_pkg.sv
// Shared constants for the sequential divider: FSM encoding and legal WIDTH range.
// Optional feature macro: DIVIDER_SIGNED_EN (two's complement operands).
package divider_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

endpackage

// File: rtl/subtractor_nbit.sv
// N-bit unsigned a-b with borrow-out; the divider uses the borrow to pick restore vs keep.
module subtractor_nbit #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  // Extend by one bit so the top bit of the result is the borrow.
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Define DIVIDER_SIGNED_EN to divide two's complement operands (magnitude
// division with a sign fix-up applied as results are registered).
//
// state | meaning
// IDLE  | waiting for start; results from the last division held
// CALC  | WIDTH shift/trial-subtract iterations in progress
// DONE  | one-cycle done pulse, results valid
module divider_seq
  import divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("divider_seq: WIDTH out of range");
  end

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] dvd_in;
  logic [WIDTH-1:0] dsr_in;
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             keep;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

  // Shift in the next dividend bit (work holds remaining dividend bits above the growing quotient).
  assign partial = {rem, work[WIDTH-1]};

  subtractor_nbit #(.N(WIDTH + 1)) u_sub (
    .a      (partial),
    .b      ({1'b0, dsr}),
    .diff   (diff),
    .borrow (borrow)
  );

  // With rem < dsr the difference never reaches bit WIDTH unless it borrowed.
  assign keep   = ~borrow & ~diff[WIDTH];
  assign r_next = keep ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  assign q_next = {work[WIDTH-2:0], keep};

`ifdef DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign dvd_in = dividend[WIDTH-1] ? -dividend : dividend;
  assign dsr_in = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign q_out  = neg_q ? -q_next : q_next;
  assign r_out  = neg_r ? -r_next : r_next;

  // Operand signs captured on acceptance drive the fix-up on the last iteration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign dvd_in = dividend;
  assign dsr_in = divisor;
  assign q_out  = q_next;
  assign r_out  = r_next;
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // FSM, iteration down-counter, datapath and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      work        <= '0;
      rem         <= '0;
      dsr         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              work        <= dvd_in;
              dsr         <= dsr_in;
              rem         <= '0;
              cnt         <= CW'(WIDTH);
              div_by_zero <= 1'b0;
              state       <= CALC;
            end
          end
        end
        CALC: begin
          work <= q_next;
          rem  <= r_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient  <= q_out;
            remainder <= r_out;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Directed self-checking bench for divider_seq at WIDTH=4.
// Signed vectors run when DIVIDER_SIGNED_EN is defined, unsigned-only vectors otherwise.
module tb_divider_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int errors = 0;
  int checks = 0;

  divider_seq #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Launch one division; lat counts rising edges from the accepting edge (inclusive) to done.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b, output int lat, output logic dbz_acc);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = ~a; divisor = ~b;
    dbz_acc = div_by_zero;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; dividend = 4'd6; divisor = 4'd5;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b, need all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_start: busy=%b, need 1", busy);
    end
    start = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (done !== 1'b1 || quotient !== 4'd1 || remainder !== 4'd1) begin
      errors++;
      $display("FAIL reset_first_result: done=%b q=%0d r=%0d, need done=1 q=1 r=1", done, quotient, remainder);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero;
    int lat;
    logic dbz_acc;
    run_div(4'd7, 4'd0, lat, dbz_acc);
    checks++;
    if (lat !== 1 || quotient !== 4'd15 || remainder !== 4'd7 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL div_zero: lat=%0d q=%0d r=%0d dbz=%b, need lat=1 q=15 r=7 dbz=1",
               lat, quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL div_zero_after: done=%b busy=%b dbz=%b, need 0 0 1", done, busy, div_by_zero);
    end
    run_div(4'd5, 4'd2, lat, dbz_acc);
    checks++;
    if (dbz_acc !== 1'b0 || quotient !== 4'd2 || remainder !== 4'd1) begin
      errors++;
      $display("FAIL div_zero_clear: dbz_at_accept=%b q=%0d r=%0d, need 0 2 1", dbz_acc, quotient, remainder);
    end
    @(posedge clk); #1;
  endtask

`ifndef DIVIDER_SIGNED_EN
  task automatic test_unsigned;
    logic [3:0] va [5];
    logic [3:0] vb [5];
    logic [3:0] eq [5];
    logic [3:0] er [5];
    int lat;
    logic dbz_acc;
    va = '{4'd13, 4'd15, 4'd3, 4'd14, 4'd0};
    vb = '{4'd4,  4'd15, 4'd9, 4'd3,  4'd7};
    eq = '{4'd3,  4'd1,  4'd0, 4'd4,  4'd0};
    er = '{4'd1,  4'd0,  4'd3, 4'd2,  4'd0};
    for (int i = 0; i < 5; i++) begin
      run_div(va[i], vb[i], lat, dbz_acc);
      checks++;
      if (lat !== 5 || quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL unsigned_%0d_%0d: lat=%0d q=%0d r=%0d dbz=%b, need lat=5 q=%0d r=%0d dbz=0",
                 va[i], vb[i], lat, quotient, remainder, div_by_zero, eq[i], er[i]);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (quotient !== eq[i] || remainder !== er[i] || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL unsigned_hold_%0d: q=%0d r=%0d busy=%b done=%b, need q=%0d r=%0d idle",
                 i, quotient, remainder, busy, done, eq[i], er[i]);
      end
    end
  endtask
`else
  task automatic test_signed;
    logic [3:0] va [3];
    logic [3:0] vb [3];
    logic [3:0] eq [3];
    logic [3:0] er [3];
    int lat;
    logic dbz_acc;
    va = '{4'b1001, 4'b1000, 4'b0111};
    vb = '{4'b0010, 4'b1111, 4'b1110};
    eq = '{4'b1101, 4'b1000, 4'b1101};
    er = '{4'b1111, 4'b0000, 4'b0001};
    for (int i = 0; i < 3; i++) begin
      run_div(va[i], vb[i], lat, dbz_acc);
      checks++;
      if (lat !== 5 || quotient !== eq[i] || remainder !== er[i]) begin
        errors++;
        $display("FAIL signed_%b_%b: lat=%0d q=%b r=%b, need lat=5 q=%b r=%b",
                 va[i], vb[i], lat, quotient, remainder, eq[i], er[i]);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  task automatic test_ignore_start;
    int pulses;
    logic [3:0] q_seen;
    logic [3:0] r_seen;
    pulses = 0; q_seen = 4'd0; r_seen = 4'd0;
    @(negedge clk); start = 1'b1; dividend = 4'd6; divisor = 4'd4;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); start = 1'b1; dividend = 4'd7; divisor = 4'd1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        q_seen = quotient;
        r_seen = remainder;
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL ignore_pulses: got %0d done pulses, need 1", pulses);
    end
    checks++;
    if (q_seen !== 4'd1 || r_seen !== 4'd2) begin
      errors++;
      $display("FAIL ignore_result: q=%0d r=%0d, need q=1 r=2", q_seen, r_seen);
    end
  endtask

  task automatic test_reset_mid_calc;
    int pulses;
    int lat;
    logic dbz_acc;
    pulses = 0;
    @(negedge clk); start = 1'b1; dividend = 4'd7; divisor = 4'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_calc: busy=%b done=%b q=%0d r=%0d dbz=%b, need all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d done pulses, need 0", pulses);
    end
    run_div(4'd5, 4'd2, lat, dbz_acc);
    checks++;
    if (lat !== 5 || quotient !== 4'd2 || remainder !== 4'd1) begin
      errors++;
      $display("FAIL reset_restart: lat=%0d q=%0d r=%0d, need lat=5 q=2 r=1", lat, quotient, remainder);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk); start = 1'b1; dividend = 4'd6; divisor = 4'd4;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
    checks++;
    if (done !== 1'b1 || quotient !== 4'd1 || remainder !== 4'd2) begin
      errors++;
      $display("FAIL b2b_first: done=%b q=%0d r=%0d, need done=1 q=1 r=2", done, quotient, remainder);
    end
    dividend = 4'd7; divisor = 4'd3;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: busy=%b done=%b, need 0 0", busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b, need 1", busy);
    end
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 4 || quotient !== 4'd2 || remainder !== 4'd1) begin
      errors++;
      $display("FAIL b2b_second: edges=%0d q=%0d r=%0d, need edges=4 q=2 r=1", n, quotient, remainder);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    test_reset();
    test_div_zero();
`ifndef DIVIDER_SIGNED_EN
    test_unsigned();
`else
    test_signed();
`endif
    test_ignore_start();
    test_reset_mid_calc();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
